// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, stalling the pipeline until the result is ready.
module muldiv_sequencer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  kill,
   input  logic [2:0]            Funct3,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Stall,
   output logic [DATA_WIDTH-1:0] Result
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t state, nextState;

   logic [2:0]   opFunct3;
   logic [W-1:0] opA, opB;
   logic [W-1:0] magA, magB;
   logic         signA, signB;
   logic [W-1:0] accHi, accLo;
   logic [CW-1:0] count;

   logic         isDiv, isRem, aSigned, bSigned;
   logic         prepSignA, prepSignB;
   logic [W-1:0] prepMagA, prepMagB;
   logic         divZero, divOverflow, specialCase;
   logic [W-1:0] specialResult;

   logic [W:0]   mulSum;
   logic [W:0]   divShifted, divDiff;
   logic         divFits;
   logic [W-1:0] calcHi, calcLo;

   logic [2*W-1:0] product, productFinal;
   logic [W-1:0]   quotientFinal, remainderFinal, fixResult;

   logic         loadResult;
   logic [W-1:0] resultNext;

   // Operand signedness: MULH/DIV/REM treat both signed, MULHSU only rs1.
   always_comb begin
      isDiv   = opFunct3[2];
      isRem   = opFunct3[2] & opFunct3[1];
      aSigned = (opFunct3 == 3'b001) | (opFunct3 == 3'b010) |
                (opFunct3 == 3'b100) | (opFunct3 == 3'b110);
      bSigned = (opFunct3 == 3'b001) | (opFunct3 == 3'b100) | (opFunct3 == 3'b110);

      prepSignA = aSigned & opA[W-1];
      prepSignB = bSigned & opB[W-1];
      prepMagA  = prepSignA ? (~opA + 1'b1) : opA;
      prepMagB  = prepSignB ? (~opB + 1'b1) : opB;

      divZero     = isDiv & (opB == '0);
      divOverflow = isDiv & ~opFunct3[0] &
                    (opA == {1'b1, {(W-1){1'b0}}}) & (opB == '1);
      specialCase = divZero | divOverflow;

      specialResult = '0;
      if (divZero) begin
         specialResult = isRem ? opA : '1;
      end else if (divOverflow) begin
         specialResult = isRem ? '0 : opA;
      end
   end

   // One iteration: multiply adds the multiplicand when the low multiplier bit
   // is set then shifts right; divide shifts in a dividend bit and subtracts
   // the divisor only if it fits (accHi = remainder, accLo = quotient).
   always_comb begin
      mulSum     = {1'b0, accHi} + (accLo[0] ? {1'b0, magA} : {(W+1){1'b0}});
      divShifted = {accHi, accLo[W-1]};
      divDiff    = divShifted - {1'b0, magB};
      divFits    = divShifted >= {1'b0, magB};

      calcHi = '0;
      calcLo = '0;
      if (isDiv) begin
         calcHi = divFits ? divDiff[W-1:0] : divShifted[W-1:0];
         calcLo = {accLo[W-2:0], divFits};
      end else begin
         calcHi = mulSum[W:1];
         calcLo = {mulSum[0], accLo[W-1:1]};
      end
   end

   // Sign correction and result selection after the last iteration.
   always_comb begin
      product        = {accHi, accLo};
      productFinal   = (signA ^ signB) ? (~product + 1'b1) : product;
      quotientFinal  = (signA ^ signB) ? (~accLo + 1'b1) : accLo;
      remainderFinal = signA ? (~accHi + 1'b1) : accHi;

      fixResult = '0;
      case (opFunct3)
         3'b000:                 fixResult = productFinal[W-1:0];
         3'b001, 3'b010, 3'b011: fixResult = productFinal[2*W-1:W];
         3'b100, 3'b101:         fixResult = quotientFinal;
         default:                fixResult = remainderFinal;
      endcase
   end

   // Next-state logic; kill overrides everything and suppresses the result write.
   always_comb begin
      nextState  = state;
      loadResult = 1'b0;
      resultNext = '0;
      case (state)
         IDLE: begin
            if (start) nextState = PREP;
         end
         PREP: begin
            if (specialCase) begin
               nextState  = DONE;
               loadResult = 1'b1;
               resultNext = specialResult;
            end else begin
               nextState = CALC;
            end
         end
         CALC: begin
            if (count == CW'(DATA_WIDTH - 1)) nextState = FIX;
         end
         FIX: begin
            nextState  = DONE;
            loadResult = 1'b1;
            resultNext = fixResult;
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
      if (kill) begin
         nextState  = IDLE;
         loadResult = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         Busy  <= 1'b0;
         Done  <= 1'b0;
      end else begin
         state <= nextState;
         Busy  <= (nextState != IDLE);
         Done  <= (nextState == DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         opFunct3 <= '0;
         opA      <= '0;
         opB      <= '0;
         magA     <= '0;
         magB     <= '0;
         signA    <= 1'b0;
         signB    <= 1'b0;
         accHi    <= '0;
         accLo    <= '0;
         count    <= '0;
         Result   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !kill) begin
                  opFunct3 <= Funct3;
                  opA      <= SrcA;
                  opB      <= SrcB;
               end
            end
            PREP: begin
               signA <= prepSignA;
               signB <= prepSignB;
               magA  <= prepMagA;
               magB  <= prepMagB;
               accHi <= '0;
               accLo <= isDiv ? prepMagA : prepMagB;
               count <= '0;
            end
            CALC: begin
               accHi <= calcHi;
               accLo <= calcLo;
               count <= count + 1'b1;
            end
            default: ;
         endcase
         if (loadResult) Result <= resultNext;
      end
   end

   // The Done cycle drops Stall so the consumer captures Result as the pipe advances.
   assign Stall = ~reset & (((state == IDLE) & start & ~kill) | (Busy & (state != DONE)));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table plus
// hand-written kill and mid-operation reset sequences.
module tb_muldiv_sequencer;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, start, kill;
   logic [2:0]   Funct3;
   logic [W-1:0] SrcA, SrcB, Result;
   logic         Busy, Done, Stall;

   int compareCount = 0;
   int errCount     = 0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.DATA_WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .kill   (kill),
      .Funct3 (Funct3),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .Busy   (Busy),
      .Done   (Done),
      .Stall  (Stall),
      .Result (Result)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Launch one op in cycle 0 and follow it until Done, tracking Stall each cycle.
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, output int latency,
                                output logic stallOk);
      latency = -1;
      stallOk = 1'b1;
      @(posedge clk); #1;
      start  = 1'b1;
      Funct3 = f3;
      SrcA   = a;
      SrcB   = b;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (Done) begin
            latency = c;
            if (Stall !== 1'b0) stallOk = 1'b0;
            break;
         end
         if (Stall !== 1'b1) stallOk = 1'b0;
         @(posedge clk); #1;
         start = 1'b0;
      end
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          latency;
      logic        stallOk;
      int          doneCycle;
      int          donePulses;
      logic [31:0] prevResult;

      vecs.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35});
      vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 35});
      vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35});
      vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35});
      vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 35});
      vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 35});
      vecs.push_back('{3'b101, 32'd100,       32'd7,         32'd14,        35});
      vecs.push_back('{3'b111, 32'd100,       32'd7,         32'd2,         35});
      vecs.push_back('{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 2});
      vecs.push_back('{3'b110, 32'd5,         32'd0,         32'd5,         2});
      vecs.push_back('{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 2});
      vecs.push_back('{3'b111, 32'd5,         32'd0,         32'd5,         2});
      vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2});
      vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2});
      vecs.push_back('{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35});
      vecs.push_back('{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 35});
      vecs.push_back('{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         35});
      vecs.push_back('{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 35});
      vecs.push_back('{3'b011, 32'h8000_0000, 32'd4,         32'd2,         35});
      vecs.push_back('{3'b001, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 35});

      // Reset with start asserted: nothing may launch and Stall stays low.
      reset  = 1'b1;
      start  = 1'b1;
      kill   = 1'b0;
      Funct3 = 3'b000;
      SrcA   = 32'h1234;
      SrcB   = 32'h5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_busy",   {31'b0, Busy},  32'd0);
      checkOutput("reset_done",   {31'b0, Done},  32'd0);
      checkOutput("reset_stall",  {31'b0, Stall}, 32'd0);
      checkOutput("reset_result", Result,         32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].f3, vecs[i].a, vecs[i].b, latency, stallOk);
         checkOutput($sformatf("vec%0d_latency", i), latency, vecs[i].lat);
         checkOutput($sformatf("vec%0d_result", i), Result, vecs[i].res);
         checkOutput($sformatf("vec%0d_stall", i), {31'b0, stallOk}, 32'd1);
      end
      prevResult = vecs[vecs.size()-1].res;

      // Kill a MUL in cycle 10, restart in cycle 11 with different operands.
      doneCycle  = -1;
      donePulses = 0;
      @(posedge clk); #1;
      Funct3 = 3'b000;
      for (int cyc = 0; cyc <= 60; cyc++) begin
         start = (cyc == 0) || (cyc == 11);
         kill  = (cyc == 10);
         SrcA  = (cyc >= 11) ? 32'd6 : 32'd1000;
         SrcB  = (cyc >= 11) ? 32'd7 : 32'd1000;
         @(negedge clk);
         if (cyc == 11) begin
            checkOutput("kill_busy",   {31'b0, Busy}, 32'd0);
            checkOutput("kill_result", Result,        prevResult);
         end
         if (Done) begin
            donePulses++;
            if (doneCycle < 0) doneCycle = cyc;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      kill  = 1'b0;
      checkOutput("kill_done_cycle",  doneCycle,  32'd46);
      checkOutput("kill_done_pulses", donePulses, 32'd1);
      checkOutput("kill_new_result",  Result,     32'd42);

      // start held high; reset pulsed in cycle 20 aborts the running op.
      doneCycle  = -1;
      donePulses = 0;
      Funct3 = 3'b000;
      SrcA   = 32'd9;
      SrcB   = 32'd9;
      for (int cyc = 0; cyc <= 60; cyc++) begin
         reset = (cyc == 20);
         start = (cyc <= 56);
         @(negedge clk);
         if (cyc == 20) checkOutput("midreset_stall", {31'b0, Stall}, 32'd0);
         if (cyc == 21) begin
            checkOutput("midreset_busy",   {31'b0, Busy}, 32'd0);
            checkOutput("midreset_done",   {31'b0, Done}, 32'd0);
            checkOutput("midreset_result", Result,        32'd0);
         end
         if (Done) begin
            donePulses++;
            if (doneCycle < 0) doneCycle = cyc;
         end
         @(posedge clk); #1;
      end
      reset = 1'b0;
      start = 1'b0;
      checkOutput("midreset_done_cycle",  doneCycle,  32'd56);
      checkOutput("midreset_done_pulses", donePulses, 32'd1);
      checkOutput("midreset_new_result",  Result,     32'd81);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", compareCount, errCount);
      $finish;
   end

endmodule
